// File: rtl/game_pkg.sv
// Shared types and helpers for the frame-based game supervisor.
package game_pkg;

    localparam int unsigned MAX_APPLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DYING,
        ST_OVER,
        ST_WIN
    } state_t;

    typedef enum logic [1:0] {
        OUT_NONE,
        OUT_APPLE,
        OUT_FATAL
    } outcome_t;

    // Number of set bits across the apple-hit vector.
    function automatic logic [2:0] popcount(input logic [MAX_APPLES-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < int'(MAX_APPLES); i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/collision_accumulator.sv
// Sticky per-frame overlap flags; cleared on every frame_end.
module collision_accumulator
    import game_pkg::*;
#(
    parameter int unsigned N_APPLES    = 1,
    parameter int unsigned SELF_HIT_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                border,
    input  logic                head,
    input  logic                body,
    input  logic [N_APPLES-1:0] apple,
    output logic                wall,
    output logic                self_hit,
    output logic [N_APPLES-1:0] hit
);

    localparam logic SELF_EN = (SELF_HIT_EN != 0);

    // Accumulate overlaps while enabled; frame boundary wipes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wall     <= 1'b0;
            self_hit <= 1'b0;
            hit      <= '0;
        end else if (clr) begin
            wall     <= 1'b0;
            self_hit <= 1'b0;
            hit      <= '0;
        end else if (en) begin
            wall     <= wall | (head & border);
            self_hit <= self_hit | (head & body & SELF_EN);
            hit      <= hit | ({N_APPLES{head}} & apple);
        end
    end

endmodule

// File: rtl/game_state_engine.sv
// Frame-based game supervisor: resolves one outcome per frame and owns
// lives, score, length and the game-phase state.
module game_state_engine
    import game_pkg::*;
#(
    parameter int unsigned LEN_W        = 8,
    parameter int unsigned INIT_LEN     = 1,
    parameter int unsigned MAX_LEN      = 64,
    parameter int unsigned N_APPLES     = 1,
    parameter int unsigned GROW         = 1,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned LIVES_W      = 2,
    parameter int unsigned SCORE_W      = 16,
    parameter int unsigned DEATH_FRAMES = 60,
    parameter int unsigned SELF_HIT_EN  = 1
) (
    input  logic                vga_clk,
    input  logic                rst_n,
    input  logic                frame_end,
    input  logic                border,
    input  logic                snake_head,
    input  logic                snake_body,
    input  logic [N_APPLES-1:0] apple,
    input  logic                start,
    input  logic                pause,
    output logic                run_en,
    output logic                snake_reset,
    output logic [N_APPLES-1:0] refresh,
    output logic [LEN_W-1:0]    length,
    output logic [SCORE_W-1:0]  score,
    output logic [LIVES_W-1:0]  lives,
    output logic                game_over,
    output logic                win
);

    localparam int unsigned CNT_W = $clog2(DEATH_FRAMES + 1);

    localparam logic [LEN_W-1:0]   LEN_INIT   = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0]   LEN_MAX    = LEN_W'(MAX_LEN);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [CNT_W-1:0]   DEATH_CNT  = CNT_W'(DEATH_FRAMES);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     dcnt_q, dcnt_d, dcnt_inc;
    logic [LEN_W-1:0]     length_d, length_grown;
    logic [SCORE_W-1:0]   score_d, score_sat;
    logic [SCORE_W:0]     score_sum;
    logic [LIVES_W-1:0]   lives_d;
    logic                 snake_reset_d;
    logic [N_APPLES-1:0]  refresh_d;
    logic [31:0]          len_sum;
    logic [2:0]           k;
    logic                 wall, self_hit;
    logic [N_APPLES-1:0]  hit;
    outcome_t             outcome;

    collision_accumulator #(
        .N_APPLES   (N_APPLES),
        .SELF_HIT_EN(SELF_HIT_EN)
    ) u_acc (
        .clk     (vga_clk),
        .rst_n   (rst_n),
        .en      ((state_q == ST_RUN) && !frame_end),
        .clr     (frame_end),
        .border  (border),
        .head    (snake_head),
        .body    (snake_body),
        .apple   (apple),
        .wall    (wall),
        .self_hit(self_hit),
        .hit     (hit)
    );

    // Frame outcome and saturating growth/score arithmetic.
    assign k            = popcount(MAX_APPLES'(hit));
    assign outcome      = (wall | self_hit) ? OUT_FATAL :
                          (k != 3'd0)       ? OUT_APPLE : OUT_NONE;
    assign len_sum      = 32'(length) + 32'(k) * GROW;
    assign length_grown = (len_sum >= MAX_LEN) ? LEN_MAX : LEN_W'(len_sum);
    assign score_sum    = {1'b0, score} + (SCORE_W+1)'(k);
    assign score_sat    = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign dcnt_inc     = dcnt_q + CNT_W'(1);

    // State register.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-value logic.
    always_comb begin
        state_d       = state_q;
        length_d      = length;
        score_d       = score;
        lives_d       = lives;
        dcnt_d        = dcnt_q;
        snake_reset_d = 1'b0;
        refresh_d     = '0;
        case (state_q)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (start) begin
                    state_d       = ST_RUN;
                    length_d      = LEN_INIT;
                    score_d       = '0;
                    lives_d       = LIVES_INIT;
                    snake_reset_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_end) begin
                    case (outcome)
                        OUT_FATAL: begin
                            length_d = LEN_INIT;
                            if (lives == LIVES_W'(1)) begin
                                lives_d = '0;
                                state_d = ST_OVER;
                            end else begin
                                lives_d = lives - LIVES_W'(1);
                                dcnt_d  = '0;
                                state_d = ST_DYING;
                            end
                        end
                        OUT_APPLE: begin
                            length_d  = length_grown;
                            score_d   = score_sat;
                            refresh_d = hit;
                            if (length_grown == LEN_MAX) begin
                                state_d = ST_WIN;
                            end
                        end
                        default: ;
                    endcase
                end
                // Pause applies only if the frame outcome left us running.
                if (pause && (state_d == ST_RUN)) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DYING: begin
                if (frame_end) begin
                    if (dcnt_inc == DEATH_CNT) begin
                        state_d       = ST_RUN;
                        snake_reset_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered datapath and output decode.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q      <= '0;
            length      <= LEN_INIT;
            score       <= '0;
            lives       <= LIVES_INIT;
            snake_reset <= 1'b0;
            refresh     <= '0;
            run_en      <= 1'b0;
            game_over   <= 1'b0;
            win         <= 1'b0;
        end else begin
            dcnt_q      <= dcnt_d;
            length      <= length_d;
            score       <= score_d;
            lives       <= lives_d;
            snake_reset <= snake_reset_d;
            refresh     <= refresh_d;
            run_en      <= (state_d == ST_RUN);
            game_over   <= (state_d == ST_OVER);
            win         <= (state_d == ST_WIN);
        end
    end

endmodule

// File: tb/tb_game_state_engine.sv
// Directed plus randomized bench for game_state_engine against a frame-level model.
module tb_game_state_engine;

    localparam int LEN_W        = 8;
    localparam int INIT_LEN     = 1;
    localparam int MAX_LEN      = 4;
    localparam int N_APPLES     = 2;
    localparam int GROW         = 1;
    localparam int LIVES        = 3;
    localparam int LIVES_W      = 2;
    localparam int SCORE_W      = 16;
    localparam int DEATH_FRAMES = 60;
    localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

    // Model game phases (bench-local numbering).
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DYING = 3;
    localparam int M_OVER  = 4;
    localparam int M_WIN   = 5;

    logic                vga_clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                frame_end = 1'b0;
    logic                border = 1'b0;
    logic                snake_head = 1'b0;
    logic                snake_body = 1'b0;
    logic [N_APPLES-1:0] apple = '0;
    logic                start = 1'b0;
    logic                pause = 1'b0;
    logic                run_en;
    logic                snake_reset;
    logic [N_APPLES-1:0] refresh;
    logic [LEN_W-1:0]    length;
    logic [SCORE_W-1:0]  score;
    logic [LIVES_W-1:0]  lives;
    logic                game_over;
    logic                win;

    game_state_engine #(
        .LEN_W(LEN_W), .INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN), .N_APPLES(N_APPLES),
        .GROW(GROW), .LIVES(LIVES), .LIVES_W(LIVES_W), .SCORE_W(SCORE_W),
        .DEATH_FRAMES(DEATH_FRAMES), .SELF_HIT_EN(1)
    ) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .frame_end(frame_end), .border(border),
        .snake_head(snake_head), .snake_body(snake_body), .apple(apple),
        .start(start), .pause(pause), .run_en(run_en), .snake_reset(snake_reset),
        .refresh(refresh), .length(length), .score(score), .lives(lives),
        .game_over(game_over), .win(win)
    );

    always #5 vga_clk = ~vga_clk;

    int total = 0;
    int bad = 0;

    int       m_mode, m_len, m_score, m_lives, m_dying;
    bit       m_fatal;
    bit [1:0] m_eaten;
    int       exp_refresh, exp_reset;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " run_en"},      run_en,      32'(m_mode == M_RUN));
        chk({tag, " game_over"},   game_over,   32'(m_mode == M_OVER));
        chk({tag, " win"},         win,         32'(m_mode == M_WIN));
        chk({tag, " length"},      length,      m_len);
        chk({tag, " score"},       score,       m_score);
        chk({tag, " lives"},       lives,       m_lives);
        chk({tag, " refresh"},     refresh,     exp_refresh);
        chk({tag, " snake_reset"}, snake_reset, exp_reset);
    endtask

    task automatic tick;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic model_reset;
        m_mode = M_IDLE; m_len = INIT_LEN; m_score = 0; m_lives = LIVES;
        m_dying = 0; m_fatal = 0; m_eaten = 0; exp_refresh = 0; exp_reset = 0;
    endtask

    // One visible pixel; overlaps only count while the game is running.
    task automatic pix(input bit b, input bit h, input bit bd, input bit [1:0] a);
        border = b; snake_head = h; snake_body = bd; apple = a;
        tick;
        border = 0; snake_head = 0; snake_body = 0; apple = '0;
        if (m_mode == M_RUN) begin
            if (h && (b || bd)) m_fatal = 1;
            if (h) m_eaten = m_eaten | a;
        end
        exp_refresh = 0; exp_reset = 0;
    endtask

    // Frame boundary with optional coincident pause; checks frame_end+1 and +2.
    task automatic end_frame(input bit p, input string tag);
        int kk;
        frame_end = 1; pause = p;
        tick;
        frame_end = 0; pause = 0;
        exp_refresh = 0; exp_reset = 0;
        if (m_mode == M_RUN) begin
            if (m_fatal) begin
                m_len = INIT_LEN;
                if (m_lives == 1) begin
                    m_lives = 0; m_mode = M_OVER;
                end else begin
                    m_lives = m_lives - 1; m_mode = M_DYING; m_dying = 0;
                end
            end else if (m_eaten != 0) begin
                kk = int'(m_eaten[0]) + int'(m_eaten[1]);
                m_len = (m_len + kk * GROW > MAX_LEN) ? MAX_LEN : m_len + kk * GROW;
                m_score = (m_score + kk > SCORE_MAX) ? SCORE_MAX : m_score + kk;
                exp_refresh = int'(m_eaten);
                if (m_len == MAX_LEN) m_mode = M_WIN;
            end
            if (p && m_mode == M_RUN) m_mode = M_PAUSE;
        end else if (m_mode == M_PAUSE) begin
            if (p) m_mode = M_RUN;
        end else if (m_mode == M_DYING) begin
            m_dying++;
            if (m_dying == DEATH_FRAMES) begin
                m_mode = M_RUN; exp_reset = 1;
            end
        end
        m_fatal = 0; m_eaten = 0;
        check_all(tag);
        tick;
        exp_refresh = 0; exp_reset = 0;
        check_all({tag, "+1"});
    endtask

    task automatic empty_frame(input string tag);
        pix(0, 0, 0, 2'b00);
        pix(0, 1, 0, 2'b00);
        end_frame(0, tag);
    endtask

    task automatic do_start(input string tag);
        start = 1;
        tick;
        start = 0;
        exp_refresh = 0; exp_reset = 0;
        if (m_mode == M_IDLE || m_mode == M_OVER || m_mode == M_WIN) begin
            m_mode = M_RUN; m_len = INIT_LEN; m_score = 0; m_lives = LIVES; exp_reset = 1;
        end
        check_all(tag);
        tick;
        exp_reset = 0;
        check_all({tag, "+1"});
    endtask

    task automatic do_pause(input string tag);
        pause = 1;
        tick;
        pause = 0;
        exp_refresh = 0; exp_reset = 0;
        if (m_mode == M_RUN) m_mode = M_PAUSE;
        else if (m_mode == M_PAUSE) m_mode = M_RUN;
        check_all(tag);
    endtask

    // Reset asserted between clock edges; outputs must clear immediately.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all(tag);
        tick;
        check_all({tag, " held"});
        @(negedge vga_clk);
        rst_n = 1;
        tick;
        check_all({tag, " released"});
    endtask

    initial begin
        bit       rb, rh, rbd, rp;
        bit [1:0] ra;
        int       r;

        model_reset();
        repeat (2) tick;
        check_all("reset");
        rst_n = 1;
        tick;
        check_all("idle");

        do_start("start");

        // apple[1] under the head for several pixels: one eat only
        pix(0, 1, 0, 2'b00);
        repeat (5) pix(0, 1, 0, 2'b10);
        end_frame(0, "eat_apple1");

        // wall and apple in one frame: death wins, apple discarded
        pix(1, 1, 0, 2'b01);
        end_frame(0, "wall_and_apple");
        repeat (DEATH_FRAMES) empty_frame("dying");

        // drain remaining lives to OVER
        pix(1, 1, 0, 2'b00);
        end_frame(0, "death2");
        repeat (DEATH_FRAMES) empty_frame("dying2");
        pix(0, 1, 1, 2'b00);
        end_frame(0, "death3_over");
        pause = 1; tick; pause = 0; check_all("pause_in_over");
        do_start("restart_after_over");

        // grow to the cap
        repeat (3) begin
            pix(0, 1, 0, 2'b01);
            end_frame(0, "grow");
        end
        pix(0, 1, 0, 2'b11);
        end_frame(0, "apple_in_win");

        // pause freezes accumulation
        do_start("restart_after_win");
        do_pause("pause_on");
        repeat (3) begin
            pix(1, 1, 0, 2'b11);
            end_frame(0, "paused_frame");
        end
        do_pause("pause_off");
        pix(0, 1, 0, 2'b01);
        end_frame(1, "eat_with_pause");
        do_start("start_in_pause");
        do_pause("pause_off2");

        // reset in the middle of a death freeze
        pix(0, 1, 1, 2'b00);
        end_frame(0, "self_hit");
        repeat (5) empty_frame("dying3");
        async_reset("reset_mid_dying");

        // randomized play
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 99);
            if (r < 6) do_start("rand_start");
            else if (r < 14) do_pause("rand_pause");
            else if (r == 99) async_reset("rand_reset");
            for (int p = 0; p < int'($urandom_range(2, 8)); p++) begin
                rh  = 1'($urandom_range(0, 1));
                rb  = ($urandom_range(0, 29) == 0);
                rbd = ($urandom_range(0, 29) == 0);
                ra  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                pix(rb, rh, rbd, ra);
            end
            rp = ($urandom_range(0, 9) == 0);
            end_frame(rp, "rand_frame");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_state_engine.md
Name: game_state_engine

Overview:
Frame-based game supervisor for the VGA snake design, and the successor to the cooldown-based top-level collision logic. It accumulates per-pixel overlap flags (head/border, head/body, head/apple[i]) across one video frame. At frame end it resolves exactly one outcome per frame, so a single apple can never be eaten twice. It owns the lives, score, length, win/lose and pause state, and drives the apple-refresh and snake-reset pulses consumed by the apple and snake controllers.

Parameters:
LEN_W, 8, width of length output
INIT_LEN, 1, length after start or death
MAX_LEN, 64, length at which WIN is declared (≤ 2^LEN_W-1)
N_APPLES, 1, independent apple channels (1..4)
GROW, 1, length increment per apple eaten
LIVES, 3, lives at game start (≥ 1)
LIVES_W, 2, width of lives counter
SCORE_W, 16, score width
DEATH_FRAMES, 60, frames frozen after a non-final death
SELF_HIT_EN, 1, 1 = head/body overlap is fatal

Ports:
vga_clk  in  1  pixel clock, single clock domain
rst_n  in  1  asynchronous active-low reset
frame_end  in  1  one-cycle pulse after last visible pixel (blanking)
border  in  1  current pixel is wall
snake_head  in  1  current pixel is snake head
snake_body  in  1  current pixel is snake body
apple  in  N_APPLES  current pixel is apple i
start  in  1  one-cycle start pulse (debounced upstream)
pause  in  1  one-cycle pause-toggle pulse
run_en  out  1  high only in RUN; gates snake movement
snake_reset  out  1  one-cycle pulse: snake returns to spawn
refresh  out  N_APPLES  one-cycle pulse: respawn apple i
length  out  LEN_W  current snake length
score  out  SCORE_W  apples eaten, saturating
lives  out  LIVES_W  remaining lives
game_over  out  1  high in OVER
win  out  1  high in WIN

Behaviour:
- Reset (async, rst_n=0): state IDLE; length=INIT_LEN; score=0; lives=LIVES; all sticky flags cleared; run_en, snake_reset, refresh, game_over and win all 0.
- States:
  - IDLE -start-> RUN: snake_reset pulse, full reinit.
  - RUN -pause-> PAUSE; PAUSE -pause-> RUN.
  - RUN -fatal-> DYING, or -fatal-> OVER if lives was 1.
  - RUN -length reaches MAX_LEN-> WIN.
  - DYING -DEATH_FRAMES frame_end pulses-> RUN, with snake_reset pulse.
  - OVER / WIN -start-> RUN: full reinit plus snake_reset.
  - start in RUN/PAUSE/DYING: ignored. pause outside RUN/PAUSE: ignored.
- Accumulation (RUN only, frame_end=0 cycles):
  - wall |= head&border
  - self |= head&body&SELF_HIT_EN
  - hit[i] |= head&apple[i]
  - Flags do not accumulate in other states.
  - All flags clear on every frame_end, in every state.
- Resolution on the frame_end cycle in RUN; registered results are visible at frame_end+1:
  - fatal (wall|self) has priority; apple hits in the same frame are discarded.
  - fatal: lives-1 and length=INIT_LEN; score is kept. If lives was 1: lives=0, OVER, game_over=1.
  - else, for k=popcount(hit)>0: length=min(length+k*GROW, MAX_LEN); score=min(score+k, 2^SCORE_W-1); refresh[i]=hit[i] for one cycle.
  - if the new length equals MAX_LEN: WIN, win=1, run_en=0.
- pause pulse coincident with frame_end in RUN: the frame is resolved first; if the outcome stays RUN, the next state is PAUSE.
- DYING frame counter: ceil(log2(DEATH_FRAMES+1)) bits, cleared on entry. It increments on frame_end; the DYING exit fires when the count reaches DEATH_FRAMES.
- run_en is a registered decode of state==RUN. snake_reset and refresh are registered one-cycle pulses and never stretch.
- Reset asserted mid-frame or mid-DYING: immediate return to reset values; no pulses are emitted.

Decomposition:
- Shared package game_pkg holds:
  - state enum: IDLE, RUN, PAUSE, DYING, OVER, WIN
  - outcome codes: NONE, APPLE, FATAL
  - the popcount function
- One sub-module, collision_accumulator: sticky per-frame flags with clear-on-frame_end and an enable input. Parameterised by N_APPLES; outputs wall, self, hit[N_APPLES-1:0].

Test Plan:
- Reset, then start -> snake_reset=1 for 1 cycle; run_en=1; length=1, lives=3, score=0.
- N_APPLES=2: head overlaps apple[1] on 5 pixels in one frame -> at frame_end+1: refresh=2'b10 for 1 cycle; length=2; score=1 (not 5).
- Head overlaps border and apple[0] in the same frame -> lives=2, length=1, refresh=0, score unchanged; state DYING. After 60 frame_end pulses: snake_reset pulse and run_en=1.
- Three fatal frames from start -> lives=0 and game_over=1. A later start gives lives=3, score=0, game_over=0.
- MAX_LEN=4, GROW=1: eat 3 apples -> length=4, win=1, run_en=0. Further apple overlaps -> no refresh pulses.
- pause in RUN -> run_en=0 and overlaps ignored for 3 frames; pause again -> RUN. Assert rst_n=0 mid-DYING -> IDLE with all outputs at reset values.
